// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shared_reg_arbiter : round-robin sequencer owning one shared WIDTH-bit register
// Revision 1.0
// ---------------------------------------------------------------------------
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  ack,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [IW-1:0]         owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    state_t           state, state_d;
    logic [IW-1:0]    ptr, ptr_d;
    logic [IW-1:0]    win, win_d;
    logic [NREQ-1:0]  gnt_d;
    logic             ack_d;
    logic [WIDTH-1:0] q_d;
    logic             q_valid_d;
    logic [IW-1:0]    owner_d;

    logic [IW-1:0]    rr_win;
    logic             rr_any;
    logic             win_req;
    logic [WIDTH-1:0] win_data;

    // Scan ptr, ptr+1, ... modulo NREQ; the first set lane wins.
    always_comb begin
        logic [IW:0] idx;
        rr_win = '0;
        rr_any = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!rr_any && req[idx[IW-1:0]]) begin
                rr_any = 1'b1;
                rr_win = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        win_req  = 1'b0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                win_req  = req[i];
                win_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        ack_d     = 1'b0;
        q_d       = q;
        q_valid_d = q_valid;
        owner_d   = owner;
        ptr_d     = ptr;
        win_d     = win;
        case (state)
            IDLE: begin
                gnt_d = '0;
                if (rr_any) begin
                    gnt_d   = NREQ'(1) << rr_win;
                    win_d   = rr_win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (win_req) begin
                    q_d       = win_data;
                    ack_d     = 1'b1;
                    owner_d   = win;
                    q_valid_d = 1'b1;
                    ptr_d     = (win == IW'(NREQ-1)) ? '0 : win + IW'(1);
                    state_d   = WRITE;
                end else begin
                    // Requester withdrew before the load: abort without touching q or ptr.
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            gnt     <= '0;
            ack     <= 1'b0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
            ptr     <= '0;
            win     <= '0;
        end else begin
            state   <= state_d;
            gnt     <= gnt_d;
            ack     <= ack_d;
            q       <= q_d;
            q_valid <= q_valid_d;
            owner   <= owner_d;
            ptr     <= ptr_d;
            win     <= win_d;
        end
    end

endmodule
`default_nettype wire
